// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register bank: sequencer states and the
// byte-merge rule used by both the storage entries and the read bypass.
package reg_bank_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } seq_state_e;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] oldByte,
                                            input logic [7:0] newByte,
                                            input logic       byteEn);
    return byteEn ? newByte : oldByte;
  endfunction

endpackage

// File: rtl/register_bank_entry.sv
// One storage word of the register bank: byte-enabled write plus a synchronous
// zero that takes priority, used by the clear sweep.
module reg_bank_entry
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_we,
  input  logic [WIDTH/8-1:0] i_be,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic               i_zero,
  output logic [WIDTH-1:0]   o_q
);

  localparam int BYTES = bytes_of(WIDTH);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q <= '0;
    end else if (i_zero) begin
      r_q <= '0;
    end else if (i_we) begin
      for (int k = 0; k < BYTES; k++) begin
        r_q[8*k +: 8] <= merge_byte(r_q[8*k +: 8], i_wdata[8*k +: 8], i_be[k]);
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_bank.sv
// General-purpose register store: DEPTH x WIDTH words, one byte-enabled write
// port, two registered read ports with write-first bypass, and a clear sweep.
module register_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [WIDTH-1:0]   i_wr_data,
  input  logic [WIDTH/8-1:0] i_wr_be,
  input  logic               i_rd_en_a,
  input  logic [ADDR_W-1:0]  i_rd_addr_a,
  output logic [WIDTH-1:0]   o_rd_data_a,
  output logic               o_rd_valid_a,
  input  logic               i_rd_en_b,
  input  logic [ADDR_W-1:0]  i_rd_addr_b,
  output logic [WIDTH-1:0]   o_rd_data_b,
  output logic               o_rd_valid_b,
  input  logic               i_clear,
  output logic               o_busy
);

  localparam int                BYTES     = bytes_of(WIDTH);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  seq_state_e        r_state;
  seq_state_e        w_nextState;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] w_nextIndex;

  logic [WIDTH-1:0]  w_entry [DEPTH];
  logic [WIDTH-1:0]  w_wrOld;
  logic [WIDTH-1:0]  w_wrMerged;
  logic [WIDTH-1:0]  w_rdValA;
  logic [WIDTH-1:0]  w_rdValB;
  logic [WIDTH-1:0]  r_rdDataA;
  logic [WIDTH-1:0]  r_rdDataB;
  logic              r_rdValidA;
  logic              r_rdValidB;

  logic w_busy;
  logic w_writeFire;
  logic w_readFireA;
  logic w_readFireB;
  logic w_sweepFire;

  assign w_busy      = (r_state == ST_CLEAR);
  assign w_writeFire = i_enable & i_wr_en & ~w_busy & ({1'b0, i_wr_addr} < DEPTH_EXT);
  assign w_readFireA = i_enable & i_rd_en_a & ~w_busy;
  assign w_readFireB = i_enable & i_rd_en_b & ~w_busy;
  assign w_sweepFire = i_enable & w_busy;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    reg_bank_entry #(
      .WIDTH (WIDTH)
    ) u_entry (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_we      (w_writeFire && (i_wr_addr == ADDR_W'(g))),
      .i_be      (i_wr_be),
      .i_wdata   (i_wr_data),
      .i_zero    (w_sweepFire && (r_index == ADDR_W'(g))),
      .o_q       (w_entry[g])
    );
  end

  // Value the addressed entry will hold after this edge's write; feeds the bypass.
  always_comb begin
    w_wrOld    = '0;
    w_wrMerged = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_wr_addr == ADDR_W'(i)) w_wrOld = w_entry[i];
    end
    for (int k = 0; k < BYTES; k++) begin
      w_wrMerged[8*k +: 8] = merge_byte(w_wrOld[8*k +: 8], i_wr_data[8*k +: 8], i_wr_be[k]);
    end
  end

  always_comb begin
    w_rdValA = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_addr_a == ADDR_W'(i)) w_rdValA = w_entry[i];
    end
    if (w_writeFire && (i_rd_addr_a == i_wr_addr)) w_rdValA = w_wrMerged;
  end

  always_comb begin
    w_rdValB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_addr_b == ADDR_W'(i)) w_rdValB = w_entry[i];
    end
    if (w_writeFire && (i_rd_addr_b == i_wr_addr)) w_rdValB = w_wrMerged;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rdDataA  <= '0;
      r_rdDataB  <= '0;
      r_rdValidA <= 1'b0;
      r_rdValidB <= 1'b0;
    end else begin
      r_rdValidA <= w_readFireA;
      r_rdValidB <= w_readFireB;
      if (w_readFireA) r_rdDataA <= w_rdValA;
      if (w_readFireB) r_rdDataB <= w_rdValB;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_nextState;
      r_index <= w_nextIndex;
    end
  end

  // The sweep only advances on enabled cycles, so a paused sweep keeps its place.
  always_comb begin
    w_nextState = r_state;
    w_nextIndex = r_index;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && i_clear) begin
          w_nextState = ST_CLEAR;
          w_nextIndex = '0;
        end
      end
      ST_CLEAR: begin
        if (i_enable) begin
          if (r_index == LAST_IDX) begin
            w_nextState = ST_IDLE;
            w_nextIndex = '0;
          end else begin
            w_nextIndex = r_index + 1'b1;
          end
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign o_rd_data_a  = r_rdDataA;
  assign o_rd_valid_a = r_rdValidA;
  assign o_rd_data_b  = r_rdDataB;
  assign o_rd_valid_b = r_rdValidB;
  assign o_busy       = w_busy;

endmodule

// File: tb/tb_register_bank.sv
// Drives a DEPTH=8 and a DEPTH=6 register bank with shared stimulus and checks
// both against an array-based reference of the bank's documented behaviour.
`timescale 1ns/1ps
module tb_register_bank;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        en      = 1'b0;
  logic        wrEn    = 1'b0;
  logic [2:0]  wrAddr  = '0;
  logic [31:0] wrData  = '0;
  logic [3:0]  wrBe    = '0;
  logic        rdEnA   = 1'b0;
  logic [2:0]  rdAddrA = '0;
  logic        rdEnB   = 1'b0;
  logic [2:0]  rdAddrB = '0;
  logic        clr     = 1'b0;

  logic [31:0] rdA8, rdB8, rdA6, rdB6;
  logic        vA8, vB8, vA6, vB6, busy8, busy6;

  int vectors = 0;
  int errors  = 0;
  int cnt8, cnt6;

  always #5 clk = ~clk;

  register_bank #(.WIDTH(32), .DEPTH(8)) u_dut8 (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en),
    .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_data(wrData), .i_wr_be(wrBe),
    .i_rd_en_a(rdEnA), .i_rd_addr_a(rdAddrA), .o_rd_data_a(rdA8), .o_rd_valid_a(vA8),
    .i_rd_en_b(rdEnB), .i_rd_addr_b(rdAddrB), .o_rd_data_b(rdB8), .o_rd_valid_b(vB8),
    .i_clear(clr), .o_busy(busy8)
  );

  register_bank #(.WIDTH(32), .DEPTH(6)) u_dut6 (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en),
    .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_data(wrData), .i_wr_be(wrBe),
    .i_rd_en_a(rdEnA), .i_rd_addr_a(rdAddrA), .o_rd_data_a(rdA6), .o_rd_valid_a(vA6),
    .i_rd_en_b(rdEnB), .i_rd_addr_b(rdAddrB), .o_rd_data_b(rdB6), .o_rd_valid_b(vB6),
    .i_clear(clr), .o_busy(busy6)
  );

  // Reference model: index 0 mirrors the 8-deep bank, index 1 the 6-deep bank.
  logic [31:0] mem [2][8];
  logic [31:0] expA [2];
  logic [31:0] expB [2];
  logic        expVA [2];
  logic        expVB [2];
  int          clearLeft [2];

  function automatic int depthOf(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  task automatic modelStep(input int k);
    int d;
    bit busy;
    d    = depthOf(k);
    busy = (clearLeft[k] != 0);
    expVA[k] = 1'b0;
    expVB[k] = 1'b0;
    if (!en) return;
    if (busy) begin
      mem[k][d - clearLeft[k]] = '0;
      clearLeft[k]--;
      return;
    end
    if (wrEn && int'(wrAddr) < d) begin
      for (int b = 0; b < 4; b++) begin
        if (wrBe[b]) mem[k][wrAddr][8*b +: 8] = wrData[8*b +: 8];
      end
    end
    if (rdEnA) begin
      expVA[k] = 1'b1;
      expA[k]  = (int'(rdAddrA) < d) ? mem[k][rdAddrA] : 32'h0;
    end
    if (rdEnB) begin
      expVB[k] = 1'b1;
      expB[k]  = (int'(rdAddrB) < d) ? mem[k][rdAddrB] : 32'h0;
    end
    if (clr) clearLeft[k] = d;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 8; i++) mem[k][i] = '0;
        expA[k]      = '0;
        expB[k]      = '0;
        expVA[k]     = 1'b0;
        expVB[k]     = 1'b0;
        clearLeft[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) modelStep(k);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both banks against the model.
  always @(posedge clk) begin
    #1;
    checkOutput("rdDataA8", rdA8, expA[0]);
    checkOutput("rdDataB8", rdB8, expB[0]);
    checkOutput("rdValidA8", 32'(vA8), 32'(expVA[0]));
    checkOutput("rdValidB8", 32'(vB8), 32'(expVB[0]));
    checkOutput("busy8", 32'(busy8), 32'(clearLeft[0] != 0));
    checkOutput("rdDataA6", rdA6, expA[1]);
    checkOutput("rdDataB6", rdB6, expB[1]);
    checkOutput("rdValidA6", 32'(vA6), 32'(expVA[1]));
    checkOutput("rdValidB6", 32'(vB6), 32'(expVB[1]));
    checkOutput("busy6", 32'(busy6), 32'(clearLeft[1] != 0));
  end

  task automatic setIdle();
    en    = 1'b1;
    wrEn  = 1'b0;
    rdEnA = 1'b0;
    rdEnB = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    rst_n   = ($urandom_range(0, 299) != 0);
    en      = ($urandom_range(0, 9) != 0);
    wrEn    = 1'($urandom_range(0, 1));
    wrAddr  = 3'($urandom_range(0, 7));
    wrData  = $urandom;
    wrBe    = 4'($urandom_range(0, 15));
    rdEnA   = 1'($urandom_range(0, 1));
    rdAddrA = ($urandom_range(0, 3) == 0) ? wrAddr : 3'($urandom_range(0, 7));
    rdEnB   = 1'($urandom_range(0, 1));
    rdAddrB = ($urandom_range(0, 3) == 0) ? rdAddrA : 3'($urandom_range(0, 7));
    clr     = ($urandom_range(0, 29) == 0);
  endtask

  task automatic fillAll();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      setIdle();
      wrEn   = 1'b1;
      wrAddr = 3'(i);
      wrData = $urandom | 32'h1;
      wrBe   = 4'hF;
    end
  endtask

  task automatic readAllZero(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      setIdle();
      rdEnA   = 1'b1;
      rdAddrA = 3'(i);
      @(posedge clk);
      #2;
      checkOutput($sformatf("%s_rdA8_%0d", tag, i), rdA8, 32'h0);
      checkOutput($sformatf("%s_vA8_%0d", tag, i), 32'(vA8), 32'h1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    setIdle();

    // Partial-byte overwrite then read back.
    @(negedge clk);
    setIdle(); wrEn = 1'b1; wrAddr = 3'd3; wrData = 32'hDEADBEEF; wrBe = 4'hF;
    @(negedge clk);
    wrBe = 4'b0010; wrData = 32'h0000AA00;
    @(negedge clk);
    setIdle(); rdEnA = 1'b1; rdAddrA = 3'd3;
    @(posedge clk);
    #2;
    checkOutput("t2_rdA8", rdA8, 32'hDEADAAEF);
    checkOutput("t2_vA8", 32'(vA8), 32'h1);
    checkOutput("t2_rdA6", rdA6, 32'hDEADAAEF);
    checkOutput("t2_model", expA[0], 32'hDEADAAEF);

    // Write-first bypass on both ports.
    @(negedge clk);
    setIdle(); wrEn = 1'b1; wrAddr = 3'd5; wrData = 32'h12345678; wrBe = 4'hF;
    rdEnA = 1'b1; rdAddrA = 3'd5; rdEnB = 1'b1; rdAddrB = 3'd5;
    @(posedge clk);
    #2;
    checkOutput("t3_rdA8", rdA8, 32'h12345678);
    checkOutput("t3_rdB8", rdB8, 32'h12345678);
    checkOutput("t3_rdB6", rdB6, 32'h12345678);
    checkOutput("t3_model", expB[1], 32'h12345678);

    // Out-of-range address on the 6-deep bank.
    @(negedge clk);
    setIdle(); wrEn = 1'b1; wrAddr = 3'd7; wrData = 32'hFFFFFFFF; wrBe = 4'hF;
    rdEnA = 1'b1; rdAddrA = 3'd7;
    @(posedge clk);
    #2;
    checkOutput("t6_rdA6", rdA6, 32'h0);
    checkOutput("t6_vA6", 32'(vA6), 32'h1);
    checkOutput("t6_rdA8", rdA8, 32'hFFFFFFFF);
    @(negedge clk);
    setIdle(); rdEnB = 1'b1; rdAddrB = 3'd7;
    @(posedge clk);
    #2;
    checkOutput("t6_rdB6", rdB6, 32'h0);
    checkOutput("t6_vB6", 32'(vB6), 32'h1);
    checkOutput("t6_rdB8", rdB8, 32'hFFFFFFFF);

    // Full sweep with a simultaneous write and writes attempted while busy.
    fillAll();
    @(negedge clk);
    setIdle(); clr = 1'b1; wrEn = 1'b1; wrAddr = 3'd2; wrData = 32'hCAFEF00D; wrBe = 4'hF;
    cnt8 = 0;
    cnt6 = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      cnt8 += int'(busy8);
      cnt6 += int'(busy6);
      @(negedge clk);
      setIdle();
      if (i <= 7) begin
        wrEn   = 1'b1;
        wrAddr = 3'($urandom_range(0, 7));
        wrData = $urandom | 32'h1;
        wrBe   = 4'hF;
        rdEnA  = 1'($urandom_range(0, 1));
        rdAddrA = 3'($urandom_range(0, 7));
      end
    end
    checkOutput("t4_busyCycles8", 32'(cnt8), 32'd8);
    checkOutput("t4_busyCycles6", 32'(cnt6), 32'd6);
    readAllZero("t4");

    // Sweep paused by three disabled cycles.
    fillAll();
    @(negedge clk);
    setIdle(); clr = 1'b1;
    cnt8 = 0;
    cnt6 = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      cnt8 += int'(busy8);
      cnt6 += int'(busy6);
      @(negedge clk);
      setIdle();
      en = !(i >= 2 && i <= 4);
    end
    checkOutput("t5_busyCycles8", 32'(cnt8), 32'd11);
    checkOutput("t5_busyCycles6", 32'(cnt6), 32'd9);

    // Reset asserted mid-sweep.
    fillAll();
    @(negedge clk);
    setIdle(); clr = 1'b1;
    @(negedge clk);
    setIdle();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t1_busy8", 32'(busy8), 32'h0);
    checkOutput("t1_busy6", 32'(busy6), 32'h0);
    checkOutput("t1_rdA8", rdA8, 32'h0);
    checkOutput("t1_vA8", 32'(vA8), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    readAllZero("t1");

    repeat (1500) applyStimulus();

    @(negedge clk);
    rst_n = 1'b1;
    setIdle();
    repeat (2) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
